sobel_stream: RTL
=================

# sobel_stream

Streaming 3x3 Sobel edge detector for the camera video path. It is the parametrised successor of the fixed-size Sobel stage. It adds configurable pixel, output and image dimensions; a valid/ready input handshake with start-of-frame alignment; border suppression; an end-of-frame flush; and selectable output modes (magnitude, |Gx|, |Gy|, thresholded binary). It sits between the camera pixel stream and the VGA frame writer, and emits exactly one output pixel per image position.

## Interface
- PIX_W, 10: input pixel width, unsigned.
- OUT_W, 10: output pixel width.
- IMG_W, 640: active pixels per line (≥4).
- IMG_H, 480: active lines per frame (≥3).
- SHIFT, 2: right shift applied to the magnitude before saturation.
- clock  in  1  master clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pix is valid this cycle.
- in_ready  out  1  block can accept a pixel; a pixel is accepted when in_valid && in_ready.
- in_sof  in  1  qualifies the accepted pixel as position (0,0).
- in_pix  in  PIX_W  raster-order pixel.
- mode  in  2  00 = |Gx|+|Gy|; 01 = |Gx|; 10 = |Gy|; 11 = threshold.
- thresh  in  OUT_W  threshold for mode 11.
- out_valid  out  1  out_pix is valid; there is no backpressure on the output.
- out_sof  out  1  out_pix is position (0,0).
- out_pix  out  OUT_W  filtered pixel.

## Operation
- Two line buffers of IMG_W×PIX_W plus a 3x3 window register shift once per accepted pixel, including during flush.
- Column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1) track the raster position of each accepted pixel.
- State machine:
  - IDLE: in_ready=1. Pixels accepted without in_sof are discarded. An accepted in_sof sets x=y=0 and goes to FILL.
  - FILL: accepts positions k=0..IMG_W, where k = y·IMG_W + x. There is no output. At k=IMG_W+1, go to RUN.
  - RUN: each accepted pixel k issues output position k−(IMG_W+1). When the last pixel (IMG_W-1, IMG_H-1) is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Issues the remaining IMG_W+1 positions, one per cycle (all of them border pixels, value 0), then goes to IDLE.
- An in_sof accepted in FILL or RUN abandons the current frame and restarts at k=0 (FILL). The abandoned frame gets no flush. Outputs already in the pipeline still drain.
- Kernels, with rows top→bottom:
  - Gx = (r02+2r12+r22) − (r00+2r10+r20)
  - Gy = (r20+2r21+r22) − (r00+2r01+r02)
- Width rules:
  - Gx and Gy are signed, PIX_W+3 bits.
  - |Gx|, |Gy| and mag are unsigned, PIX_W+3 bits. mag = |Gx|+|Gy| for mode 00, |Gx| for mode 01, |Gy| for mode 10.
  - scaled = mag >> SHIFT, saturated to 2^OUT_W−1.
  - Mode 11 computes mag as in mode 00, then out = all-ones if scaled ≥ thresh, else 0.
- Border: an output position with x=0, x=IMG_W-1, y=0 or y=IMG_H-1 is forced to 0 in every mode, including mode 11.
- mode and thresh are sampled together with the accepted pixel (or flush step) that issues the output. A change takes effect on the next issued output.
- out_sof is 1 only on the output for position (0,0).

## Timing
- Reset values: out_valid=0, out_sof=0, out_pix=0, state IDLE, x=y=0, in_ready=1.
- Line buffer contents are not reset.
- Latency: an output issued in cycle t (accept or flush step) appears with out_valid=1 at cycle t+3. The three pipeline stages are: Gx/Gy, abs/select, scale/saturate/threshold/border.
- out_valid is high for exactly one cycle per issued output. It is never high without a matching issue, so in_valid gaps produce out_valid gaps.
- in_ready is low for exactly IMG_W+1 cycles after the final pixel is accepted. It is 1 again in the following cycle, and an in_sof may be accepted in that cycle.
- A full frame produces IMG_W·IMG_H outputs. The last output appears IMG_W+4 cycles after the last pixel is accepted.
- A reset_n assertion in any state immediately clears the outputs and pipeline valids and returns to IDLE.

## Test plan
- IMG_W=8, IMG_H=6, PIX_W=OUT_W=8, SHIFT=0, mode 00, flat frame of value 100, continuous in_valid → 48 outputs, all 0; out_sof on the first output; in_ready low for 9 cycles after the last pixel.
- Same setup, columns 0–3 = 0 and columns 4–7 = 255 → rows 1–4 give 255 at x=3 and x=4 (1020 saturated), 0 elsewhere. Mode 01 gives the same result; mode 10 gives all 0.
- Same setup, mode 11, thresh=20, single pixel of value 10 at (3,2) on a zero background → the 8 neighbours of (3,2) output 255; (3,2) and all other positions output 0.
- Stimulus of the second scenario with in_valid toggling 1,0,1,0 → identical output values in identical order; each out_valid comes exactly 3 cycles after its accept.
- Reset mid-frame:
  - reset_n low for 2 cycles during RUN → out_valid=0 from the next cycle.
  - Pixels without in_sof are then ignored.
  - The next in_sof frame reproduces the first scenario exactly.
- in_sof reasserted at k=20 of a frame → no flush occurs; the new frame's output (0,0) carries out_sof and the output count restarts at 48.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector. Two line buffers and a 3x3 window feed
// three pipeline stages: Gx/Gy, abs/select, then scale/saturate/threshold/border.
module sobel_stream #(
    parameter int PIX_W = 10,
    parameter int OUT_W = 10,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] thresh,
    output logic             out_valid,
    output logic             out_sof,
    output logic [OUT_W-1:0] out_pix
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int GW = PIX_W + 3;
    localparam int CW = (GW > OUT_W) ? GW : OUT_W;
    localparam int FW = $clog2(IMG_W + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [FW-1:0] F_LAST = FW'(IMG_W);

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             border;
        logic [1:0]       mode;
        logic [OUT_W-1:0] thresh;
        logic [GW-1:0]    gx;
        logic [GW-1:0]    gy;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic             border;
        logic             thr;
        logic [OUT_W-1:0] thresh;
        logic [GW-1:0]    mag;
    } s2_t;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic [OUT_W-1:0] pix;
    } s3_t;

    logic [1:0]                 state_q, state_d;
    logic [XW-1:0]              x_q, x_d, ox_q, ox_d;
    logic [YW-1:0]              y_q, y_d, oy_q, oy_d;
    logic [FW-1:0]              fcnt_q, fcnt_d;
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic [PIX_W-1:0]           lb_top_q [IMG_W];
    logic [PIX_W-1:0]           lb_mid_q [IMG_W];
    s1_t                        s1_q, s1_d;
    s2_t                        s2_q, s2_d;
    s3_t                        s3_q, s3_d;

    logic             accept, flushing, restart, shift, issue;
    logic [XW-1:0]    pos_x;
    logic [YW-1:0]    pos_y;
    logic [PIX_W-1:0] col_pix;
    logic [GW-1:0]    gx_pos, gx_neg, gy_pos, gy_neg, ax, ay;
    logic [CW-1:0]    scaled;
    logic [OUT_W-1:0] sat;

    // x/y track the input raster; ox/oy track the position of the next issued output.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        in_ready = (state_q != S_FLUSH);
        flushing = (state_q == S_FLUSH);
        accept   = in_valid && in_ready;
        restart  = accept && in_sof;
        pos_x    = restart ? '0 : x_q;
        pos_y    = restart ? '0 : y_q;
        shift    = (accept && (restart || state_q != S_IDLE)) || flushing;
        issue    = (accept && !in_sof && state_q == S_RUN) || flushing;
        col_pix  = flushing ? '0 : in_pix;

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        fcnt_d  = fcnt_q;

        if (shift) begin
            if (pos_x == X_LAST) begin
                x_d = '0;
                y_d = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
            end else begin
                x_d = pos_x + 1'b1;
                y_d = pos_y;
            end
        end

        if (issue) begin
            if (ox_q == X_LAST) begin
                ox_d = '0;
                oy_d = (oy_q == Y_LAST) ? '0 : oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end

        if (restart) begin
            state_d = S_FILL;
            ox_d    = '0;
            oy_d    = '0;
        end else begin
            case (state_q)
                S_FILL:  if (accept && pos_x == '0 && pos_y == YW'(1)) state_d = S_RUN;
                S_RUN: begin
                    if (accept && pos_x == X_LAST && pos_y == Y_LAST) begin
                        state_d = S_FLUSH;
                        fcnt_d  = '0;
                    end
                end
                S_FLUSH: begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (fcnt_q == F_LAST) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Stage 1 uses the window as it will be after this shift, so Gx/Gy register
    // in the issuing cycle and the output lands three cycles later.
    always_comb begin
        win_d = win_q;
        if (shift) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_top_q[pos_x];
            win_d[1][2] = lb_mid_q[pos_x];
            win_d[2][2] = col_pix;
        end

        gx_pos = GW'(win_d[0][2]) + (GW'(win_d[1][2]) << 1) + GW'(win_d[2][2]);
        gx_neg = GW'(win_d[0][0]) + (GW'(win_d[1][0]) << 1) + GW'(win_d[2][0]);
        gy_pos = GW'(win_d[2][0]) + (GW'(win_d[2][1]) << 1) + GW'(win_d[2][2]);
        gy_neg = GW'(win_d[0][0]) + (GW'(win_d[0][1]) << 1) + GW'(win_d[0][2]);

        s1_d.valid  = issue;
        s1_d.sof    = issue && ox_q == '0 && oy_q == '0;
        s1_d.border = (ox_q == '0) || (ox_q == X_LAST) || (oy_q == '0) || (oy_q == Y_LAST);
        s1_d.mode   = mode;
        s1_d.thresh = thresh;
        s1_d.gx     = gx_pos - gx_neg;
        s1_d.gy     = gy_pos - gy_neg;

        ax = s1_q.gx[GW-1] ? (~s1_q.gx + 1'b1) : s1_q.gx;
        ay = s1_q.gy[GW-1] ? (~s1_q.gy + 1'b1) : s1_q.gy;
        s2_d.valid  = s1_q.valid;
        s2_d.sof    = s1_q.sof;
        s2_d.border = s1_q.border;
        s2_d.thr    = (s1_q.mode == 2'b11);
        s2_d.thresh = s1_q.thresh;
        case (s1_q.mode)
            2'b01:   s2_d.mag = ax;
            2'b10:   s2_d.mag = ay;
            default: s2_d.mag = ax + ay;
        endcase

        scaled     = CW'(s2_q.mag >> SHIFT);
        sat        = (scaled > CW'({OUT_W{1'b1}})) ? '1 : scaled[OUT_W-1:0];
        s3_d.valid = s2_q.valid;
        s3_d.sof   = s2_q.sof;
        if (s2_q.border)   s3_d.pix = '0;
        else if (s2_q.thr) s3_d.pix = (sat >= s2_q.thresh) ? '1 : '0;
        else               s3_d.pix = sat;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            fcnt_q  <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            fcnt_q  <= fcnt_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
        end
    end

    // NOTE: line buffers and window are datapath storage and are deliberately not reset.
    always_ff @(posedge clock) begin
        win_q <= win_d;
        if (shift) begin
            lb_top_q[pos_x] <= lb_mid_q[pos_x];
            lb_mid_q[pos_x] <= col_pix;
        end
    end

    assign out_valid = s3_q.valid;
    assign out_sof   = s3_q.sof;
    assign out_pix   = s3_q.pix;

endmodule
